// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data SRAM port between the MEM stage and a host master
module dmem_port_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 64,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cpu_enable,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_wen,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {S_NORM = 1'b0, S_HACK = 1'b1} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] hrd_q;
    logic              creq;
    logic              heq;
    logic              host_grant;
    logic              cpu_grant;

    // Eligibility and single-winner grant: CPU by default, host once it has waited long enough
    always_comb begin
        creq       = cpu_req & cpu_enable;
        heq        = host_req & (state == S_NORM);
        host_grant = heq & (~creq | (wait_cnt >= HOLD_LIM));
        cpu_grant  = creq & ~host_grant;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= S_NORM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a host grant is always followed by exactly one ack cycle
    always_comb begin
        state_nxt = S_NORM;
        if (state == S_NORM && host_grant) begin
            state_nxt = S_HACK;
        end
    end

    // Port mux, stall, ack and host read data; control strobes are held low during reset
    always_comb begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        if (host_grant) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wen   = host_wen;
            mem_ren   = ~host_wen;
        end else if (cpu_grant) begin
            mem_wen   = cpu_wen;
            mem_ren   = ~cpu_wen;
        end
        cpu_stall  = creq & ~cpu_grant;
        host_ack   = (state == S_HACK);
        host_rdata = (state == S_HACK && !host_wen) ? mem_rdata : hrd_q;
        if (!arst_n) begin
            mem_wen   = 1'b0;
            mem_ren   = 1'b0;
            cpu_stall = 1'b0;
            host_ack  = 1'b0;
        end
    end

    // Load data reaches the pipeline with the same timing as a direct SRAM connection
    assign cpu_rdata = mem_rdata;

    // Host wait counter: counts lost cycles, frozen during the ack cycle
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wait_cnt <= '0;
        end else if (state == S_NORM) begin
            if (host_grant || !host_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != HOLD_LIM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Host read data holding register, captured in the ack cycle of a read
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            hrd_q <= '0;
        end else if (state == S_HACK && !host_wen) begin
            hrd_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cpu_enable, cpu_req, cpu_wen;
    logic [63:0] cpu_addr, cpu_wdata;
    logic        host_req, host_wen;
    logic [63:0] host_addr, host_wdata;
    logic [63:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, host_ack, mem_wen, mem_ren;
    logic [63:0] mem_rdata;

    logic [63:0] h0_cpu_rdata, h0_host_rdata, h0_mem_addr, h0_mem_wdata;
    logic        h0_cpu_stall, h0_host_ack, h0_mem_wen, h0_mem_ren;
    wire  [63:0] zero_data = '0;

    logic [63:0] sram [0:255];
    bit          init_done = 1'b0;

    logic [63:0] cpu_q[$];
    logic [63:0] host_q[$];
    logic [63:0] exp_hrd;
    int          n_chk = 0;
    int          n_bad = 0;

    logic        chk_h0 = 1'b0;
    logic        e_h0_stall, e_h0_wen, e_h0_ack;
    logic [63:0] e_h0_addr;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .arst_n(arst_n), .cpu_enable(cpu_enable), .cpu_req(cpu_req),
        .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .host_req(host_req),
        .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_port_arbiter #(.MAX_HOLD(0)) dut_h0 (
        .clk(clk), .arst_n(arst_n), .cpu_enable(cpu_enable), .cpu_req(cpu_req),
        .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(h0_cpu_rdata), .cpu_stall(h0_cpu_stall), .host_req(host_req),
        .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(h0_host_ack), .host_rdata(h0_host_rdata), .mem_addr(h0_mem_addr),
        .mem_wen(h0_mem_wen), .mem_ren(h0_mem_ren), .mem_wdata(h0_mem_wdata),
        .mem_rdata(zero_data)
    );

    // Synchronous-read SRAM model behind the main instance
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) sram[i] <= {32'hA5A5_5A5A, 24'h0, i[7:0]};
            init_done <= 1'b1;
            mem_rdata <= '0;
        end else begin
            if (mem_wen) sram[mem_addr[7:0]] <= mem_wdata;
            if (mem_ren) mem_rdata <= sram[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic cen, input logic creq, input logic cwen,
                         input logic [63:0] caddr, input logic [63:0] cwdata,
                         input logic hreq, input logic hwen,
                         input logic [63:0] haddr, input logic [63:0] hwdata);
        cpu_enable = cen;  cpu_req = creq;  cpu_wen = cwen;
        cpu_addr = caddr;  cpu_wdata = cwdata;
        host_req = hreq;   host_wen = hwen;
        host_addr = haddr; host_wdata = hwdata;
    endtask

    // One clock cycle: compare outputs mid-cycle, settle scoreboard, then advance
    task automatic step(input string tag, input logic e_ren, input logic e_wen,
                        input logic [63:0] e_addr, input logic [63:0] e_wdata,
                        input logic e_stall, input logic e_ack,
                        input logic cpu_rd, input logic chk_hrd);
        logic [63:0] exp_c;
        @(negedge clk);
        if (cpu_q.size() > 0) begin
            exp_c = cpu_q.pop_front();
            chk({tag, ".cpu_rdata"}, cpu_rdata, exp_c);
        end
        chk({tag, ".ren"},   {63'd0, mem_ren},   {63'd0, e_ren});
        chk({tag, ".wen"},   {63'd0, mem_wen},   {63'd0, e_wen});
        chk({tag, ".addr"},  mem_addr, e_addr);
        chk({tag, ".wdata"}, mem_wdata, e_wdata);
        chk({tag, ".stall"}, {63'd0, cpu_stall}, {63'd0, e_stall});
        chk({tag, ".ack"},   {63'd0, host_ack},  {63'd0, e_ack});
        if (e_ack && host_q.size() > 0) exp_hrd = host_q.pop_front();
        if (chk_hrd) chk({tag, ".host_rdata"}, host_rdata, exp_hrd);
        if (chk_h0) begin
            chk({tag, ".h0_stall"}, {63'd0, h0_cpu_stall}, {63'd0, e_h0_stall});
            chk({tag, ".h0_wen"},   {63'd0, h0_mem_wen},   {63'd0, e_h0_wen});
            chk({tag, ".h0_ack"},   {63'd0, h0_host_ack},  {63'd0, e_h0_ack});
            chk({tag, ".h0_addr"},  h0_mem_addr, e_h0_addr);
        end
        if (cpu_rd) cpu_q.push_back(sram[e_addr[7:0]]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_hrd = '0;
        arst_n  = 1'b0;
        // reset: strobes forced low even with both requesters active
        drive(1, 1, 1, 64'h40, 64'h99, 1, 0, 64'h18, 0);
        step("rst0", 0, 0, 64'h40, 64'h99, 0, 0, 0, 1);
        step("rst1", 0, 0, 64'h40, 64'h99, 0, 0, 0, 1);
        arst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle0", 0, 0, 0, 0, 0, 0, 0, 1);

        // cpu-only reads of 0x10
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 64'h10, 0, 0, 0, 0, 0);
            step("cpu_only", 1, 0, 64'h10, 0, 0, 0, 1, 1);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle1", 0, 0, 0, 0, 0, 0, 0, 1);

        // host-only with core disabled; cpu_req must be ignored
        drive(0, 1, 1, 64'h50, 64'h77, 1, 1, 64'h20, 64'hDEADBEEF);
        step("hwr_grant", 0, 1, 64'h20, 64'hDEADBEEF, 0, 0, 0, 1);
        step("hwr_ack", 0, 0, 64'h50, 64'h77, 0, 1, 0, 1);
        drive(0, 1, 1, 64'h50, 64'h77, 1, 0, 64'h20, 0);
        host_q.push_back(64'hDEADBEEF);
        step("hrd_grant", 1, 0, 64'h20, 0, 0, 0, 0, 1);
        step("hrd_ack", 0, 0, 64'h50, 64'h77, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("hrd_hold", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("hrd_const", exp_hrd, 64'hDEADBEEF);

        // continuous contention with MAX_HOLD=4
        drive(1, 1, 0, 64'h10, 0, 1, 0, 64'h18, 0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) step("cont_cpu", 1, 0, 64'h10, 0, 0, 0, 1, 1);
            host_q.push_back(sram[8'h18]);
            step("cont_host", 1, 0, 64'h18, 0, 1, 0, 0, 1);
            step("cont_ack", 1, 0, 64'h10, 0, 0, 1, 1, 1);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle2", 0, 0, 0, 0, 0, 0, 0, 1);
        step("idle3", 0, 0, 0, 0, 0, 0, 0, 1);

        // simultaneous first cycle: cpu wins at MAX_HOLD=4, host wins at MAX_HOLD=0
        drive(1, 1, 0, 64'h10, 0, 1, 1, 64'h28, 64'h1234);
        chk_h0 = 1'b1; e_h0_stall = 1'b1; e_h0_wen = 1'b1; e_h0_ack = 1'b0; e_h0_addr = 64'h28;
        step("simul", 1, 0, 64'h10, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 64'h10, 0, 1, 1, 64'h28, 64'h1234);
        e_h0_stall = 1'b0; e_h0_wen = 1'b0; e_h0_ack = 1'b1; e_h0_addr = 64'h10;
        step("simul_h", 0, 1, 64'h28, 64'h1234, 0, 0, 0, 1);
        chk_h0 = 1'b0;
        step("simul_ack", 0, 0, 64'h10, 0, 0, 1, 0, 1);
        chk("simul_sram", sram[8'h28], 64'h1234);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle4", 0, 0, 0, 0, 0, 0, 0, 1);

        // host read acked while the cpu writes the same word
        drive(1, 0, 0, 64'h30, 0, 1, 0, 64'h30, 0);
        host_q.push_back(sram[8'h30]);
        step("rw_grant", 1, 0, 64'h30, 0, 0, 0, 0, 1);
        drive(1, 1, 1, 64'h30, 64'h5, 1, 0, 64'h30, 0);
        step("rw_ack", 0, 1, 64'h30, 64'h5, 0, 1, 0, 1);
        chk("rw_sram", sram[8'h30], 64'h5);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rw_hold", 0, 0, 0, 0, 0, 0, 0, 1);

        // reset during the ack cycle aborts the transaction
        drive(1, 0, 0, 0, 0, 1, 0, 64'h18, 0);
        step("rh_grant", 1, 0, 64'h18, 0, 0, 0, 0, 1);
        arst_n = 1'b0;
        drive(1, 1, 1, 64'h40, 64'h99, 1, 0, 64'h18, 0);
        step("rh_rst", 0, 0, 64'h40, 64'h99, 0, 0, 0, 0);
        exp_hrd = '0;
        arst_n  = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rh_after", 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1, 0, 64'h18, 0);
        host_q.push_back(sram[8'h18]);
        step("rh_reissue", 1, 0, 64'h18, 0, 0, 0, 0, 1);
        step("rh_ack", 0, 0, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rh_hold", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rh_value", exp_hrd, {32'hA5A5_5A5A, 32'h18});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
